i2c_codec_target: RTL and testbench

- Behavioural and synthesizable I2C target (slave) model of the WM8731 control port.
- Receives the 3-byte write frames the codec init sequence emits: device address/W, then {reg[6:0], data[8]}, then data[7:0].
- ACKs each byte and stores 9-bit register values in an internal register file.
- Used in the lab3 bench as the far end of the I2C bus, and on-chip as a loopback checker.

---
 rtl/i2c_codec_target.sv | 118 +++++++++++
 tb/tb_i2c_codec_target.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target modelling the WM8731 control port with a 9-bit register file
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'b0011010,
  parameter int         NUM_REGS = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_err,
  output logic [7:0] o_frame_cnt
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [6:0] NREG = 7'(NUM_REGS);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, DONE_WAIT, IGNORE} state_t;
  state_t      state;
  logic [2:0]  scl_s, sda_s, cnt;
  logic [6:0]  sh, reg_idx;
  logic [7:0]  dat, byte_in;
  logic        d8, sda_low, commit;
  logic [8:0]  regs [NUM_REGS];
  logic        scl_q, scl_d, sda_q, sda_d, start, stop, scl_rise, scl_fall, byte_done, shifting;
  assign scl_q     = scl_s[1];
  assign scl_d     = scl_s[2];
  assign sda_q     = sda_s[1];
  assign sda_d     = sda_s[2];
  assign start     = scl_q && scl_d && sda_d && !sda_q;
  assign stop      = scl_q && scl_d && !sda_d && sda_q;
  assign scl_rise  = scl_q && !scl_d;
  assign scl_fall  = !scl_q && scl_d;
  assign shifting  = state == ADDR || state == BYTE1 || state == BYTE2 || state == DONE_WAIT;
  assign byte_in   = {sh, sda_q};
  assign byte_done = scl_rise && cnt == 3'd7;
  assign io_sda    = sda_low ? 1'b0 : 1'bz;
  assign o_rd_data = ({3'b0, i_rd_addr} < NREG) ? regs[i_rd_addr[AW-1:0]] : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_s       <= 3'b111;
      sda_s       <= 3'b111;
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      reg_idx     <= '0;
      d8          <= 1'b0;
      dat         <= '0;
      sda_low     <= 1'b0;
      commit      <= 1'b0;
      o_wr_valid  <= 1'b0;
      o_err       <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      scl_s      <= {scl_s[1:0], i_scl};
      sda_s      <= {sda_s[1:0], io_sda};
      o_wr_valid <= 1'b0;
      o_err      <= 1'b0;
      commit     <= 1'b0;
      // the commit is already final once ACK2 is released, so bus conditions cannot cancel it
      if (commit) begin
        if (reg_idx < NREG) begin
          regs[reg_idx[AW-1:0]] <= {d8, dat};
          o_wr_addr   <= reg_idx;
          o_wr_data   <= {d8, dat};
          o_wr_valid  <= 1'b1;
          o_frame_cnt <= o_frame_cnt + 8'd1;
        end else o_err <= 1'b1;
      end
      if (start || stop) begin
        state   <= start ? ADDR : IDLE;
        cnt     <= '0;
        sda_low <= 1'b0;
      end else begin
        if (scl_rise && shifting) begin
          sh  <= byte_in[6:0];
          cnt <= cnt + 3'd1;
        end
        case (state)
          ADDR:      if (byte_done) state <= (byte_in[7:1] == DEV_ADDR && !byte_in[0]) ? ADDR_ACK : IGNORE;
          BYTE1:     if (byte_done) begin
            reg_idx <= byte_in[7:1];
            d8      <= byte_in[0];
            state   <= ACK1;
          end
          BYTE2:     if (byte_done) begin
            dat   <= byte_in;
            state <= ACK2;
          end
          DONE_WAIT: if (byte_done) begin
            o_err <= 1'b1;
            state <= IGNORE;
          end
          // first falling edge grabs SDA, the next one releases it and advances
          ADDR_ACK:  if (scl_fall) begin
            sda_low <= !sda_low;
            if (sda_low) state <= BYTE1;
          end
          ACK1:      if (scl_fall) begin
            sda_low <= !sda_low;
            if (sda_low) state <= BYTE2;
          end
          ACK2:      if (scl_fall) begin
            sda_low <= !sda_low;
            commit  <= sda_low;
            if (sda_low) state <= DONE_WAIT;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_codec_target.sv
// tb_i2c_codec_target: drives I2C write frames at the target and checks it against a register-map model
module tb_i2c_codec_target;
  localparam int Q = 4;
  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  logic [3:0] rd_addr = '0;
  wire        sda;
  logic [8:0] rd_data, wr_data;
  logic [6:0] wr_addr;
  logic [7:0] frame_cnt;
  logic       wr_valid, err;
  int tests = 0, fails = 0;
  int wr_pulses = 0, err_pulses = 0, dut_low = 0, viol = 0;
  logic prev_drv = 1'b0, prev_scl = 1'b1;
  logic [8:0] mregs [16];
  logic [8:0] init_v [10];
  int exp_wr = 0, exp_err = 0;
  logic [7:0] exp_cnt = '0;
  logic [6:0] exp_waddr = '0;
  logic [8:0] exp_wdata = '0;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  i2c_codec_target dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .io_sda(sda),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_wr_valid(wr_valid),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_err(err), .o_frame_cnt(frame_cnt)
  );
  always @(negedge clk) begin
    logic drv;
    drv = (sda === 1'b0) && !m_low;
    if (wr_valid) wr_pulses++;
    if (err) err_pulses++;
    if (drv) dut_low++;
    if (drv != prev_drv && scl && prev_scl) viol++;
    prev_drv = drv;
    prev_scl = scl;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask
  task automatic i2c_stop();
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0; tick(Q);
  endtask
  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = !b[i]; tick(Q);
      scl = 1'b1;    tick(2 * Q);
      scl = 1'b0;    tick(Q);
    end
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    ack = (sda === 1'b0);
    tick(Q);
    scl = 1'b0;   tick(Q);
  endtask
  task automatic clear_model();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    exp_cnt = '0; exp_waddr = '0; exp_wdata = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(2);
    clear_model();
  endtask
  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick(1);
      check(tag, rd_data, mregs[i]);
    end
  endtask
  task automatic expect_write(input logic [6:0] r, input logic [8:0] v);
    if (r < 7'd10) begin
      mregs[r[3:0]] = v;
      exp_wr++; exp_cnt++;
      exp_waddr = r; exp_wdata = v;
    end else exp_err++;
  endtask
  task automatic check_status();
    check("wr_pulses", wr_pulses, exp_wr);
    check("err_pulses", err_pulses, exp_err);
    check("frame_cnt", frame_cnt, exp_cnt);
    check("wr_addr", wr_addr, exp_waddr);
    check("wr_data", wr_data, exp_wdata);
  endtask
  task automatic run_frame(input logic [7:0] a, b1, b2, input bit extra, input logic [7:0] b3, output int nacks);
    bit ok, k;
    logic [3:0] acks;
    int low0;
    ok = a[7:1] == 7'b0011010 && !a[0];
    low0 = dut_low;
    acks = '0;
    i2c_start();
    send_byte(a, k);  acks[0] = k;
    send_byte(b1, k); acks[1] = k;
    send_byte(b2, k); acks[2] = k;
    if (extra) begin
      send_byte(b3, k); acks[3] = k;
    end
    i2c_stop();
    tick(4 * Q);
    if (ok) begin
      expect_write(b1[7:1], {b1[0], b2});
      if (extra) exp_err++;
    end
    check("ack", acks, ok ? 4'b0111 : 4'b0000);
    if (!ok) check("nack_sda_low", dut_low - low0, 0);
    check_status();
    nacks = int'(acks[0]) + int'(acks[1]) + int'(acks[2]) + int'(acks[3]);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, total;
    bit k;
    logic [7:0] a, b1, b2, b3;
    init_v = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h015, 9'h000, 9'h000, 9'h042, 9'h019, 9'h001};
    clear_model();
    tick(3);
    check("rst_sda", sda, 1'b1);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_frame_cnt", frame_cnt, 8'd0);
    check("rst_wr_addr", wr_addr, 7'd0);
    check("rst_wr_data", wr_data, 9'd0);
    rst = 1'b0;
    tick(2);
    check_regs("rst_reg");
    run_frame(8'h34, 8'h00, 8'h97, 1'b0, 8'h00, n);
    check("basic_acks", n, 3);
    rd_addr = 4'd0; tick(1);
    check("basic_reg0", rd_data, 9'h097);
    check("basic_cnt", frame_cnt, 8'd1);
    do_reset();
    total = 0;
    for (int i = 0; i < 10; i++) begin
      run_frame(8'h34, {7'(i), init_v[i][8]}, init_v[i][7:0], 1'b0, 8'h00, n);
      total += n;
    end
    check("init_acks", total, 30);
    check("init_cnt", frame_cnt, 8'd10);
    rd_addr = 4'd4; tick(1); check("init_reg4", rd_data, 9'h015);
    rd_addr = 4'd7; tick(1); check("init_reg7", rd_data, 9'h042);
    rd_addr = 4'd8; tick(1); check("init_reg8", rd_data, 9'h019);
    rd_addr = 4'd9; tick(1); check("init_reg9", rd_data, 9'h001);
    check_regs("init_reg");
    run_frame(8'h36, 8'h02, 8'h55, 1'b0, 8'h00, n);
    check("wrong_dev_cnt", frame_cnt, 8'd10);
    run_frame(8'h34, 8'h1E, 8'h00, 1'b0, 8'h00, n);
    check("oor_acks", n, 3);
    check_regs("oor_reg");
    total = 0;
    i2c_start();
    send_byte(8'h34, k); total += int'(k);
    send_byte(8'h02, k); total += int'(k);
    i2c_start();
    send_byte(8'h34, k); total += int'(k);
    send_byte(8'h02, k); total += int'(k);
    send_byte(8'h79, k); total += int'(k);
    i2c_stop();
    tick(4 * Q);
    expect_write(7'd1, 9'h079);
    check("rstart_acks", total, 5);
    rd_addr = 4'd1; tick(1);
    check("rstart_reg1", rd_data, 9'h079);
    check_status();
    check_regs("rstart_reg");
    run_frame(8'h34, 8'h04, 8'h11, 1'b1, 8'hAA, n);
    check("extra_acks", n, 3);
    i2c_start();
    send_byte(8'h34, k);
    send_byte(8'h0C, k);
    for (int i = 0; i < 4; i++) begin
      m_low = i[0]; tick(Q);
      scl = 1'b1;   tick(2 * Q);
      scl = 1'b0;   tick(Q);
    end
    m_low = 1'b0;
    rst = 1'b1; tick(1);
    check("midrst_sda", sda, 1'b1);
    rst = 1'b0; tick(1);
    clear_model();
    check("midrst_cnt", frame_cnt, 8'd0);
    check("midrst_wr_addr", wr_addr, 7'd0);
    check_regs("midrst_reg");
    scl = 1'b1; tick(2 * Q);
    run_frame(8'h34, 8'h0E, 8'h5A, 1'b0, 8'h00, n);
    rd_addr = 4'd7; tick(1);
    check("postrst_reg7", rd_data, 9'h05A);
    for (int it = 0; it < 24; it++) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      b1 = 8'($urandom_range(0, 31));
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      run_frame(a, b1, b2, $urandom_range(0, 4) == 0, b3, n);
    end
    check_regs("rand_reg");
    check("sda_change_scl_high", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
